// File: rtl/jk_ms_register_bank.sv
// rtl/jk_ms_register_bank.sv - master-slave JK register bank with optional commit gating
// Optional change counter built only when JK_CHANGE_CNT_EN is defined.
module jk_ms_register_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               AUTO_COMMIT = 1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             commit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] q_changed,
    output logic [WIDTH-1:0] mq,
    output logic [CNT_W-1:0] q_change_cnt
);

    logic [WIDTH-1:0] master_r;
    logic [WIDTH-1:0] master_next;
    logic [WIDTH-1:0] slave_r;
    logic [WIDTH-1:0] slave_next;
    logic [WIDTH-1:0] changed_r;
    logic             slave_take;

    always_comb begin
        master_next = master_r;
        if (load) begin
            master_next = load_data;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b01:   master_next[i] = 1'b0;
                    2'b10:   master_next[i] = 1'b1;
                    2'b11:   master_next[i] = ~master_r[i];
                    default: master_next[i] = master_r[i];
                endcase
            end
        end
    end

    // The slave always copies the pre-edge master, so new master data never
    // passes straight through to q on the edge it is written.
    assign slave_take = (AUTO_COMMIT != 0) || commit;
    assign slave_next = slave_take ? master_r : slave_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            master_r  <= RESET_VAL;
            slave_r   <= RESET_VAL;
            changed_r <= '0;
        end else begin
            master_r  <= master_next;
            slave_r   <= slave_next;
            changed_r <= slave_next ^ slave_r;
        end
    end

`ifdef JK_CHANGE_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((slave_next != slave_r) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign q_change_cnt = cnt_r;
`else
    assign q_change_cnt = '0;
`endif

    assign q         = slave_r;
    assign q_bar     = ~slave_r;
    assign q_changed = changed_r;
    assign mq        = master_r;

endmodule

// File: tb/tb_jk_ms_register_bank.sv
// tb/tb_jk_ms_register_bank.sv - randomized and directed check of jk_ms_register_bank
// Instance 0 runs AUTO_COMMIT=1, instance 1 runs AUTO_COMMIT=0 on shared inputs.
module tb_jk_ms_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  j = '0;
    logic [7:0]  k = '0;
    logic        load = 1'b0;
    logic [7:0]  load_data = '0;
    logic        commit = 1'b0;

    logic [7:0]  q_o     [2];
    logic [7:0]  qb_o    [2];
    logic [7:0]  chg_o   [2];
    logic [7:0]  mq_o    [2];
    logic [15:0] cnt_o   [2];

    logic [7:0]  m_mq    [2];
    logic [7:0]  m_q     [2];
    logic [7:0]  m_chg   [2];
    logic [15:0] m_cnt   [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    jk_ms_register_bank #(.WIDTH(8), .RESET_VAL(8'h00), .AUTO_COMMIT(1), .CNT_W(16)) dut_auto (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .load_data(load_data),
        .commit(commit), .q(q_o[0]), .q_bar(qb_o[0]), .q_changed(chg_o[0]), .mq(mq_o[0]),
        .q_change_cnt(cnt_o[0])
    );

    jk_ms_register_bank #(.WIDTH(8), .RESET_VAL(8'h00), .AUTO_COMMIT(0), .CNT_W(16)) dut_gated (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .load_data(load_data),
        .commit(commit), .q(q_o[1]), .q_bar(qb_o[1]), .q_changed(chg_o[1]), .mq(mq_o[1]),
        .q_change_cnt(cnt_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: JK characteristic equation on the master, slave copies the
    // previous master when committing, counter counts edges where q moves.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] qn;
            if (rst) begin
                m_mq[i]  = 8'h00;
                m_q[i]   = 8'h00;
                m_chg[i] = 8'h00;
                m_cnt[i] = 16'd0;
            end else begin
                qn = ((i == 0) || commit) ? m_mq[i] : m_q[i];
                m_chg[i] = qn ^ m_q[i];
`ifdef JK_CHANGE_CNT_EN
                if (m_chg[i] != 8'h00 && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
`else
                m_cnt[i] = 16'd0;
`endif
                if (load)    m_mq[i] = load_data;
                else if (en) m_mq[i] = (j & ~m_mq[i]) | (~k & m_mq[i]);
                m_q[i] = qn;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("q[%0d]", i),         {24'd0, q_o[i]},   {24'd0, m_q[i]});
                check($sformatf("q_bar[%0d]", i),     {24'd0, qb_o[i]},  {24'd0, ~m_q[i]});
                check($sformatf("mq[%0d]", i),        {24'd0, mq_o[i]},  {24'd0, m_mq[i]});
                check($sformatf("q_changed[%0d]", i), {24'd0, chg_o[i]}, {24'd0, m_chg[i]});
                check($sformatf("cnt[%0d]", i),       {16'd0, cnt_o[i]}, {16'd0, m_cnt[i]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        step(2);
        chk_on = 1'b1;
        rst = 1'b0;
        check("rst_q",     {24'd0, q_o[0]},   32'h00);
        check("rst_qbar",  {24'd0, qb_o[0]},  32'hFF);
        check("rst_mq",    {24'd0, mq_o[0]},  32'h00);
        check("rst_chg",   {24'd0, chg_o[0]}, 32'h00);
        check("rst_cnt",   {16'd0, cnt_o[0]}, 32'h0);

        en = 1'b1; j = 8'h0F; k = 8'h00;
        step(1);
        check("set_mq_e1", {24'd0, mq_o[0]},  32'h0F);
        check("set_q_e1",  {24'd0, q_o[0]},   32'h00);
        en = 1'b0;
        step(1);
        check("set_q_e2",  {24'd0, q_o[0]},   32'h0F);
        check("set_chg_e2", {24'd0, chg_o[0]}, 32'h0F);
        step(1);
        check("set_chg_e3", {24'd0, chg_o[0]}, 32'h00);

        en = 1'b1; j = 8'hFF; k = 8'hFF;
        step(1);
        check("tog_mq1", {24'd0, mq_o[0]}, 32'hF0);
        check("tog_q1",  {24'd0, q_o[0]},  32'h0F);
        step(1);
        check("tog_mq2", {24'd0, mq_o[0]}, 32'h0F);
        check("tog_q2",  {24'd0, q_o[0]},  32'hF0);
        check("tog_chg2", {24'd0, chg_o[0]}, 32'hFF);
        step(1);
        check("tog_mq3", {24'd0, mq_o[0]}, 32'hF0);
        check("tog_chg3", {24'd0, chg_o[0]}, 32'hFF);
        en = 1'b0;
        step(1);
        check("tog_q4",  {24'd0, q_o[0]},  32'hF0);

        load = 1'b1; load_data = 8'hA5; en = 1'b1; j = 8'hFF; k = 8'h00;
        step(1);
        check("load_wins", {24'd0, mq_o[0]}, 32'hA5);
        load = 1'b0; en = 1'b0;
        step(4);
        check("gated_hold_q",  {24'd0, q_o[1]},  32'h00);
        check("gated_hold_mq", {24'd0, mq_o[1]}, 32'hA5);
        commit = 1'b1; load = 1'b1; load_data = 8'h3C;
        step(1);
        check("commit_old_q",  {24'd0, q_o[1]},  32'hA5);
        check("commit_new_mq", {24'd0, mq_o[1]}, 32'h3C);
        load = 1'b0;
        step(1);
        check("commit2_q", {24'd0, q_o[1]}, 32'h3C);
        commit = 1'b0;

        en = 1'b1; j = 8'hFF; k = 8'hFF;
        step(3);
        rst = 1'b1; load = 1'b1; load_data = 8'h77; commit = 1'b1;
        step(1);
        check("midrst_mq0", {24'd0, mq_o[0]}, 32'h00);
        check("midrst_q0",  {24'd0, q_o[0]},  32'h00);
        check("midrst_mq1", {24'd0, mq_o[1]}, 32'h00);
        check("midrst_q1",  {24'd0, q_o[1]},  32'h00);
        check("midrst_cnt", {16'd0, cnt_o[0]}, 32'h0);
        rst = 1'b0; load = 1'b0; commit = 1'b0;

        en = 1'b1; j = 8'h01; k = 8'h00; step(1);
        j = 8'h00; k = 8'h01; step(1);
        j = 8'h01; k = 8'h00; step(1);
        en = 1'b0; step(1);
`ifdef JK_CHANGE_CNT_EN
        check("cnt_three", {16'd0, cnt_o[0]}, 32'd3);
`else
        check("cnt_tied", {16'd0, cnt_o[0]}, 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 31) == 0);
            en        = $urandom_range(0, 1);
            load      = ($urandom_range(0, 3) == 0);
            commit    = ($urandom_range(0, 2) == 0);
            j         = 8'($urandom);
            k         = 8'($urandom);
            load_data = 8'($urandom);
            step(1);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
